// File: rtl/data_mem_if.sv
// ---------------------------------------------------------------------------
// data_mem_if
//   Request/response bundle between the EX/MEM pipeline register and the
//   MEM-stage data memory.
//
//   Signals:
//     we        store request this cycle
//     re        load request this cycle (only qualifies the error flags)
//     mem_op    access type: 000 word, 001 half unsigned, 010 half signed,
//               011 byte unsigned, 100 byte signed, 101-111 reserved
//     addr      byte address (ALU result)
//     wdata     store data (rt after forwarding)
//     pc        PC of the instruction in MEM (write log only)
//     rdata     extended load data (feeds DMOut_in of MEM/WB)
//     align_err misaligned access
//     range_err address beyond the end of memory
//
//   Modports: master drives the request, slave is the memory.
// ---------------------------------------------------------------------------
interface data_mem_if;
  logic        we;
  logic        re;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        align_err;
  logic        range_err;

  modport master (
    output we, re, mem_op, addr, wdata, pc,
    input  rdata, align_err, range_err
  );

  modport slave (
    input  we, re, mem_op, addr, wdata, pc,
    output rdata, align_err, range_err
  );
endinterface

// File: rtl/data_mem_stage.sv
// ---------------------------------------------------------------------------
// data_mem_stage
//   Data memory of the MEM stage. Word-organised, little-endian storage with
//   synchronous byte/half/word stores and combinational, sign- or
//   zero-extended loads.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high; clears every memory word
//     bus    data_mem_if.slave (we, re, mem_op, addr, wdata, pc in;
//            rdata, align_err, range_err out)
//
//   Parameters:
//     DEPTH_WORDS  number of 32-bit words
//     AW           word-index width, 2**AW >= DEPTH_WORDS
//
//   Optional build macro:
//     DM_WRITE_LOG_EN  when defined, every committed store prints
//                      "<time>@<pc>: *<word addr> <= <merged word>".
// ---------------------------------------------------------------------------
module data_mem_stage #(
  parameter int DEPTH_WORDS = 3072,
  parameter int AW          = 12
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus
);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HU   = 3'b001;
  localparam logic [2:0] OP_HS   = 3'b010;
  localparam logic [2:0] OP_BU   = 3'b011;
  localparam logic [2:0] OP_BS   = 3'b100;

  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          in_range;
  logic [31:0]   sel_word;

  logic          is_word;
  logic          is_half;
  logic          is_byte;
  logic          is_reserved;
  logic          misaligned;
  logic          active;
  logic          any_err;
  logic          commit;

  logic [3:0]    byte_en;
  logic [31:0]   merged_word;
  logic [31:0]   load_data;

  assign idx      = bus.addr[AW+1:2];
  assign lane     = bus.addr[1:0];
  assign in_range = (bus.addr[31:2] < DEPTH_LIMIT);

  // Out-of-range indices would alias past the array end; feed zero instead.
  assign sel_word = in_range ? mem[idx] : 32'h0;

  always_comb begin
    is_word     = 1'b0;
    is_half     = 1'b0;
    is_byte     = 1'b0;
    is_reserved = 1'b0;
    unique case (bus.mem_op)
      OP_WORD:      is_word     = 1'b1;
      OP_HU, OP_HS: is_half     = 1'b1;
      OP_BU, OP_BS: is_byte     = 1'b1;
      default:      is_reserved = 1'b1;
    endcase
  end

  // A reserved op only counts as misaligned when it tries to store.
  assign misaligned = (is_word && (lane != 2'b00))
                    || (is_half && lane[0])
                    || (is_reserved && bus.we);

  assign active        = (bus.we || bus.re) && !reset;
  assign bus.align_err = active && misaligned;
  assign bus.range_err = active && !in_range;
  assign any_err       = bus.align_err || bus.range_err;
  assign commit        = bus.we && !reset && !any_err && !is_reserved;

  // Lane merge: each byte lane takes either store data or the current word.
  // The data source for a lane depends on the access size: word stores take
  // the matching byte, half stores repeat wdata[15:0], byte stores wdata[7:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src_byte;

      assign byte_en[gi] = is_word
                         || (is_half && (bus.addr[1] == gi[1]))
                         || (is_byte && (lane == gi[1:0]));

      always_comb begin
        src_byte = bus.wdata[7:0];
        if (is_word)
          src_byte = bus.wdata[8*gi +: 8];
        else if (is_half)
          src_byte = bus.wdata[8*(gi%2) +: 8];
      end

      assign merged_word[8*gi +: 8] = byte_en[gi] ? src_byte : sel_word[8*gi +: 8];
    end
  endgenerate

  // Load path: select and extend the addressed lanes.
  always_comb begin
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    half_sel  = sel_word[16*bus.addr[1] +: 16];
    byte_sel  = sel_word[8*lane +: 8];
    load_data = 32'h0;
    unique case (bus.mem_op)
      OP_WORD: load_data = sel_word;
      OP_HU:   load_data = {16'h0, half_sel};
      OP_HS:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_BU:   load_data = {24'h0, byte_sel};
      OP_BS:   load_data = {{24{byte_sel[7]}}, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

  assign bus.rdata = (reset || any_err) ? 32'h0 : load_data;

  // Storage. Reset clears the whole array and overrides a concurrent store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= 32'h0;
    end else if (commit) begin
      mem[idx] <= merged_word;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (commit)
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_data_mem_stage
//   Self-checking bench for data_mem_stage: directed vector table, reset
//   sequences, and randomized traffic compared to a byte-addressed model.
// ---------------------------------------------------------------------------
module tb_data_mem_stage;

  localparam int DEPTH_WORDS = 3072;
  localparam int DEPTH_BYTES = DEPTH_WORDS * 4;

  logic clk;
  logic reset;

  data_mem_if bus ();

  data_mem_stage #(.DEPTH_WORDS(DEPTH_WORDS), .AW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: plain byte array, little-endian.
  logic [7:0] model_mem [DEPTH_BYTES];

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_al;
    logic        exp_rg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH_BYTES; i++) model_mem[i] = 8'h0;
  endtask

  // Expected outputs from the architectural rules.
  task automatic model_eval(input logic w, input logic r, input logic [2:0] op,
                            input logic [31:0] a,
                            output logic [31:0] rd, output logic al, output logic rg);
    int    sz;
    logic  reserved, oor, mis;
    int    base;
    logic [31:0] v;
    sz       = op_size(op);
    reserved = (sz == 0);
    oor      = (a >= 32'(DEPTH_BYTES));
    mis      = reserved ? w : ((a % 32'(sz)) != 0);
    al       = (w | r) & mis;
    rg       = (w | r) & oor;
    rd       = 32'h0;
    if (!(al || rg || reserved || oor)) begin
      base = int'(a - (a % 32'(sz)));
      v = 32'h0;
      for (int k = 0; k < sz; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
      if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      if (op == 3'd4 && v[7])  v = v | 32'hFFFF_FF00;
      rd = v;
    end
  endtask

  task automatic model_store(input logic w, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic al, input logic rg);
    int sz;
    sz = op_size(op);
    if (w && !al && !rg && sz != 0)
      for (int k = 0; k < sz; k++) model_mem[int'(a) + k] = d[8*k +: 8];
  endtask

  // Drive one transaction mid-cycle, sample 2ns later, let the next
  // posedge commit it, then update the model.
  task automatic run_op(input string nm, input logic w, input logic r,
                        input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic chk_rd, input logic [31:0] erd,
                        input logic eal, input logic erg);
    @(negedge clk);
    bus.we = w; bus.re = r; bus.mem_op = op; bus.addr = a; bus.wdata = d;
    bus.pc = 32'h0040_0000 + a;
    #2;
    $display("%s: we=%0b re=%0b op=%0d addr=%h wdata=%h -> rdata=%h al=%0b rg=%0b",
             nm, w, r, op, a, d, bus.rdata, bus.align_err, bus.range_err);
    if (chk_rd) check({nm, " rdata"}, bus.rdata, erd);
    check({nm, " align_err"}, 32'(bus.align_err), 32'(eal));
    check({nm, " range_err"}, 32'(bus.range_err), 32'(erg));
    model_store(w, op, a, d, eal, erg);
    @(posedge clk);
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.re = 1'b0; bus.mem_op = 3'd0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.pc = 32'h0;
  endtask

  task automatic add(input logic w, input logic r, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d, input logic c,
                     input logic [31:0] erd, input logic eal, input logic erg);
    vec_t v;
    v.we = w; v.re = r; v.op = op; v.addr = a; v.wdata = d;
    v.chk_rd = c; v.exp_rd = erd; v.exp_al = eal; v.exp_rg = erg;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eal, erg;
    logic        w, r;
    logic [2:0]  op;
    logic [31:0] a, d;

    idle();
    model_clear();

    // Reset with a bad, out-of-range store request pending: outputs held at 0.
    reset = 1'b1;
    bus.we = 1'b1; bus.re = 1'b1; bus.mem_op = 3'd0;
    bus.addr = 32'h0000_3001; bus.wdata = 32'hFFFF_FFFF;
    @(negedge clk); #2;
    $display("reset: rdata=%h al=%0b rg=%0b", bus.rdata, bus.align_err, bus.range_err);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset align_err", 32'(bus.align_err), 32'h0);
    check("reset range_err", 32'(bus.range_err), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    //   we    re    op    addr          wdata          chk   exp_rd         al    rg
    add(1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd3, 32'h0000_0022, 32'h0000_00AB, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0020, 32'h0,         1'b1, 32'h11AB_3344, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_0040, 32'h0000_80F0, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd4, 32'h0000_0040, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd3, 32'h0000_0040, 32'h0,         1'b1, 32'h0000_00F0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 32'h0000_0040, 32'h0,         1'b1, 32'hFFFF_80F0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'h0000_0040, 32'h0,         1'b1, 32'h0000_80F0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_0042, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0040, 32'h0,         1'b1, 32'h0000_80F0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 32'h0000_0041, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd4, 32'h0000_0041, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0, 1'b1);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_0050, 32'h0000_0005, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b1, 1'b1, 3'd0, 32'h0000_0050, 32'h0000_0007, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0050, 32'h0,         1'b1, 32'h0000_0007, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd5, 32'h0000_0050, 32'h0000_FFFF, 1'b1, 32'h0,         1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd6, 32'h0000_0050, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0050, 32'h0,         1'b1, 32'h0000_0007, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd1, 32'h0000_0052, 32'hCAFE_1234, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h0000_0050, 32'h0,         1'b1, 32'h1234_0007, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_3002, 32'h1,         1'b1, 32'h0,         1'b1, 1'b1);
    add(1'b0, 1'b0, 3'd0, 32'h0000_0041, 32'h0,         1'b1, 32'h0000_80F0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h0000_2FFC, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd4, 32'h0000_2FFF, 32'h0,         1'b1, 32'hFFFF_FFA5, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].re, vecs[i].op, vecs[i].addr,
             vecs[i].wdata, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_al, vecs[i].exp_rg);

    // Reset asserted with a legal store pending: the store is dropped and
    // the earlier contents are cleared.
    run_op("pre_rst_st", 1'b1, 1'b0, 3'd0, 32'h60, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.we = 1'b1; bus.re = 1'b1; bus.mem_op = 3'd0; bus.addr = 32'h64; bus.wdata = 32'h99;
    #2;
    $display("rst_store: rdata=%h al=%0b rg=%0b", bus.rdata, bus.align_err, bus.range_err);
    check("rst_store rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    model_clear();
    run_op("post_rst_60", 1'b0, 1'b1, 3'd0, 32'h60, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    run_op("post_rst_64", 1'b0, 1'b1, 3'd0, 32'h64, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Randomized traffic against the byte model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      w  = 1'($urandom_range(0, 1));
      r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sel = $urandom_range(0, 19);
      if (sel < 2)
        a = 32'h0000_2FF0 + 32'($urandom_range(0, 31));
      else if (sel == 2)
        a = $urandom;
      else
        a = 32'($urandom_range(0, 63));
      d = $urandom;
      model_eval(w, r, op, a, erd, eal, erg);
      run_op($sformatf("rnd%0d", i), w, r, op, a, d, 1'b1, erd, eal, erg);
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
